// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM state encoding and datapath widths
package alu_pkg;
  localparam int W = 16;
  localparam int AW = 3;
  localparam int NREG = 8;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR = 2'b11;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
endpackage

// File: rtl/alu.sv
// alu: 16-bit add/sub/and/or, op/i0/i1 in, o/cout out, carry-in taken from op[0]
module alu
  import alu_pkg::*;
(
  input  logic [1:0]   op,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  output logic [W-1:0] o,
  output logic         cout
);
  logic [W:0] sum;
  assign sum = {1'b0, i0} + {1'b0, op[0] ? ~i1 : i1} + {{W{1'b0}}, op[0]};
  assign o = op[1] ? (op[0] ? i0 | i1 : i0 & i1) : sum[W-1:0];
  assign cout = ~op[1] & sum[W];
endmodule

// File: rtl/regfile8x16.sv
// regfile8x16: 8x16 registers, async read ports ra/rda and rb/rdb, one write port muxed from wb_* (priority) or ld_*
module regfile8x16
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [W-1:0]  rda,
  output logic [W-1:0]  rdb
);
  logic [W-1:0] rf [NREG];
  logic [AW-1:0] wa;
  logic [W-1:0] wd;
  assign wa = wb_en ? wb_addr : ld_addr;
  assign wd = wb_en ? wb_data : ld_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    else if (wb_en | ld_en)
      rf[wa] <= wd;
  assign rda = rf[ra];
  assign rdb = rf[rb];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: cmd_* handshake into a READ/EXEC/WB sequencer around alu and regfile8x16; ld_* loads when idle; res_*/carry_flag/busy report writebacks
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  output logic [AW-1:0] res_rd,
  output logic          carry_flag,
  output logic          busy
);
  state_t state, nxt;
  logic rdy_q, cout_q, carry_q, alu_c, acc;
  logic [1:0] op_q;
  logic [AW-1:0] rd_q, rs1_q, rs2_q, res_rd_q;
  logic [W-1:0] opa, opb, res_q, alu_o, rda, rdb;
  assign cmd_ready = rdy_q & (state == IDLE);
  assign acc = cmd_valid & cmd_ready;
  assign busy = state != IDLE;
  assign res_valid = state == WB;
  assign res_data = res_q;
  assign res_rd = res_rd_q;
  assign carry_flag = carry_q;
  regfile8x16 u_rf (
    .clk(clk), .rst_n(rst_n),
    .wb_en(state == WB), .wb_addr(rd_q), .wb_data(res_q),
    .ld_en(ld_en & ~busy), .ld_addr(ld_addr), .ld_data(ld_data),
    .ra(rs1_q), .rb(rs2_q), .rda(rda), .rdb(rdb)
  );
  alu u_alu (.op(op_q), .i0(opa), .i1(opb), .o(alu_o), .cout(alu_c));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (acc ? READ : IDLE) : state == READ ? EXEC : state == EXEC ? WB : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_q <= 1'b0;
      op_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      opa <= '0;
      opb <= '0;
      res_q <= '0;
      cout_q <= 1'b0;
      res_rd_q <= '0;
      carry_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (acc) {op_q, rd_q, rs1_q, rs2_q} <= {cmd_op, cmd_rd, cmd_rs1, cmd_rs2};
      if (state == READ) {opa, opb} <= {rda, rdb};
      if (state == EXEC) {res_q, cout_q, res_rd_q} <= {alu_o, alu_c, rd_q};
      if (state == WB && !op_q[1]) carry_q <= cout_q;
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed table plus multi-cycle sequences for alu_issue_ctrl
module tb_alu_issue_ctrl;
  import alu_pkg::*;
  logic clk = 0, rst_n = 0, cmd_valid = 0, ld_en = 0;
  logic cmd_ready, res_valid, carry_flag, busy;
  logic [1:0] cmd_op = 0;
  logic [2:0] cmd_rd = 0, cmd_rs1 = 0, cmd_rs2 = 0, ld_addr = 0, res_rd;
  logic [15:0] ld_data = 0, res_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .carry_flag(carry_flag), .busy(busy)
  );
  typedef struct {
    logic ld;
    logic [1:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [15:0] a, b, res;
    logic c;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 0;
  endtask
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, rs1, rs2,
                       input logic [15:0] er, input logic ec, input string nm);
    int k;
    logic rdy_busy;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_valid = 1;
    chk({nm, "_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0; ld_en = 0;
    k = 1; rdy_busy = 0;
    while (!res_valid && k < 8) begin
      rdy_busy |= cmd_ready;
      @(negedge clk);
      k++;
    end
    rdy_busy |= cmd_ready;
    chk({nm, "_lat"}, k, 3);
    chk({nm, "_rdy_low"}, rdy_busy, 0);
    chk({nm, "_data"}, res_data, er);
    chk({nm, "_rd"}, res_rd, rd);
    @(negedge clk);
    chk({nm, "_vld_pulse"}, res_valid, 0);
    chk({nm, "_carry"}, carry_flag, ec);
  endtask
  initial begin
    int acc, nres, last;
    v[0] = '{1, OP_ADD, 3, 1, 2, 16'h0005, 16'h0003, 16'h0008, 0};
    v[1] = '{1, OP_ADD, 4, 1, 2, 16'hFFFF, 16'h0001, 16'h0000, 1};
    v[2] = '{1, OP_AND, 4, 1, 2, 16'hFFFF, 16'h0001, 16'h0001, 1};
    v[3] = '{1, OP_SUB, 3, 1, 2, 16'h0003, 16'h0005, 16'hFFFE, 0};
    v[4] = '{1, OP_SUB, 7, 1, 2, 16'h0005, 16'h0003, 16'h0002, 1};
    v[5] = '{1, OP_OR, 5, 5, 6, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1};
    v[6] = '{0, OP_OR, 7, 5, 5, 16'h0000, 16'h0000, 16'hFFFF, 1};
    v[7] = '{1, OP_ADD, 1, 1, 1, 16'h4000, 16'h4000, 16'h8000, 0};
    v[8] = '{0, OP_OR, 2, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0};
    v[9] = '{0, OP_SUB, 3, 3, 3, 16'h0000, 16'h0000, 16'h0000, 1};
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vld", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_rd", res_rd, 0);
    chk("rst_carry", carry_flag, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rel_ready", cmd_ready, 1);
    for (int i = 0; i < 10; i++) begin
      if (v[i].ld) begin
        load(v[i].rs1, v[i].a);
        if (v[i].rs2 != v[i].rs1) load(v[i].rs2, v[i].b);
      end
      issue(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].res, v[i].c, $sformatf("vec%0d", i));
    end
    ld_en = 1; ld_addr = 2; ld_data = 16'h1234;
    issue(OP_OR, 7, 2, 2, 16'h1234, 1, "ld_same_cycle");
    load(1, 16'h0001);
    load(2, 16'h0001);
    cmd_op = OP_ADD; cmd_rd = 1; cmd_rs1 = 1; cmd_rs2 = 2; cmd_valid = 1;
    acc = 0; nres = 0; last = 0;
    for (int i = 0; i < 80 && nres < 10; i++) begin
      if (res_valid) begin
        chk("b2b_res", res_data, 32'(2 + nres));
        nres++;
      end
      if (cmd_valid && cmd_ready) begin
        if (acc > 0) chk("b2b_gap", i - last, 4);
        last = i;
        acc++;
      end
      ld_en = (i == 6); ld_addr = 6; ld_data = 16'hDEAD;
      @(negedge clk);
      if (acc == 10) cmd_valid = 0;
    end
    ld_en = 0;
    chk("b2b_accepts", acc, 10);
    chk("b2b_results", nres, 10);
    issue(OP_OR, 7, 6, 6, 16'h0F0F, 0, "ld_busy_dropped");
    load(1, 16'hFFFF);
    load(2, 16'h0001);
    issue(OP_ADD, 4, 1, 2, 16'h0000, 1, "pre_rst");
    cmd_op = OP_ADD; cmd_rd = 5; cmd_rs1 = 1; cmd_rs2 = 2; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_carry", carry_flag, 0);
    @(negedge clk);
    chk("mid_rst_vld", res_valid, 0);
    rst_n = 1;
    @(negedge clk);
    chk("mid_rel_ready", cmd_ready, 1);
    chk("mid_rel_vld", res_valid, 0);
    chk("mid_rel_data", res_data, 0);
    chk("mid_rel_rd", res_rd, 0);
    @(negedge clk);
    chk("mid_rel_vld2", res_valid, 0);
    issue(OP_OR, 3, 1, 2, 16'h0000, 0, "post_rst_regs");
    issue(OP_OR, 6, 4, 5, 16'h0000, 0, "post_rst_regs2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
